// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction memory
// and buffers returned words with their addresses in a small prefetch FIFO.
module fetch_unit #(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter int                      FIFO_DEPTH   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] target_pc,
  input  logic                    instr_ready,
  output logic                    instr_valid,
  output logic [31:0]             instruction,
  output logic [ADDRESS_BITS-1:0] pc_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]             NOP       = 32'h0000_0013;
  localparam logic [ADDRESS_BITS-1:0] WORD_STEP = ADDRESS_BITS'(4);
  localparam logic [CW:0]             DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]           FULL      = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]           LAST_PTR  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           count, outstanding, stale;
  logic [CW-1:0]           outstanding_next, stale_next;
  logic [CW:0]             in_use;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [ADDRESS_BITS-1:0] resp_addr, target_aligned;
  logic [31:0]             word_mem [FIFO_DEPTH];
  logic [ADDRESS_BITS-1:0] pc_mem   [FIFO_DEPTH];
  logic                    issue, resp, push, pop;
  logic                    unused_target_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign target_aligned     = {target_pc[ADDRESS_BITS-1:2], 2'b00};
  assign unused_target_lsbs = ^target_pc[1:0];

  // Requests are withheld while old responses drain, so every accepted response
  // belongs to the sequential stream that starts at resp_addr.
  assign in_use      = (CW + 1)'(outstanding) + (CW + 1)'(count);
  assign imem_req    = (state == RUN) && (in_use < DEPTH_W) && !redirect;
  assign issue       = imem_req && imem_gnt;
  assign resp        = imem_rvalid && (outstanding != '0);
  assign push        = resp && (stale == '0) && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? word_mem[rd_ptr] : NOP;
  assign pc_o        = instr_valid ? pc_mem[rd_ptr]   : RESET_PC;

  assign outstanding_next = outstanding + CW'(issue) - CW'(resp);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    stale_next = stale;
    if (redirect)
      stale_next = outstanding_next;
    else if (resp && (stale != '0))
      stale_next = stale - 1'b1;

    case (state)
      BOOT:       state_next = RUN;
      RUN, DRAIN: state_next = (stale_next != '0) ? DRAIN : RUN;
      default:    state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= BOOT;
      imem_addr   <= RESET_PC;
      resp_addr   <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // NOTE: the FIFO storage is reset too, so no word from before reset can ever reappear.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_mem[i] <= NOP;
        pc_mem[i]   <= RESET_PC;
      end
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      stale       <= stale_next;

      if (redirect)
        imem_addr <= target_aligned;
      else if (issue)
        imem_addr <= imem_addr + WORD_STEP;

      if (redirect) begin
        count     <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        resp_addr <= target_aligned;
      end else begin
        if (push) begin
          word_mem[wr_ptr] <= imem_rdata;
          pc_mem[wr_ptr]   <= resp_addr;
          wr_ptr           <= ptr_inc(wr_ptr);
          resp_addr        <= resp_addr + WORD_STEP;
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count == FULL)));

endmodule
